// File: rtl/asteroid_pkg.sv
`default_nettype none
// ============================================================================
// Module      : asteroid_pkg
// Description : Shared definitions for the asteroid collision block: default
//               asteroid count, default score width and the game-state enum.
// Revision    : 1.0 - initial release
// ============================================================================
package asteroid_pkg;

  localparam int DEFAULT_ASTEROID_COUNT = 10;
  localparam int DEFAULT_SCORE_W        = 16;

  typedef enum logic [0:0] {
    PLAY = 1'b0,
    OVER = 1'b1
  } game_state_e;

endpackage
`default_nettype wire

// File: rtl/popcount.sv
`default_nettype none
// ============================================================================
// Module      : popcount
// Description : Combinational population count of a WIDTH-bit vector.
// Ports       : bits  - input vector
//               count - number of 1 bits, $clog2(WIDTH+1) wide
// Revision    : 1.0 - initial release
// ============================================================================
module popcount #(
  parameter int WIDTH = 10
) (
  input  logic [WIDTH-1:0]             bits,
  output logic [$clog2(WIDTH+1)-1:0]   count
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + CNT_W'(bits[i]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/asteroid_collide.sv
`default_nettype none
// ============================================================================
// Module      : asteroid_collide
// Description : Pixel-level bullet/asteroid and ship/asteroid collision
//               detection. Bullet hits are collected per frame and committed
//               one clock after the frame pulse as one-clk shot pulses, a
//               single bullet_hit pulse and a saturating score update.
// Config      : define SHIP_COLLIDE_EN to enable the PLAY/OVER game FSM;
//               without it game_over is tied to 0 and ship_drawing ignored.
// Ports       : clk            - pixel clock
//               rst            - asynchronous active-high reset
//               frame          - one-clk pulse at start of vertical blank
//               ast_drawing    - per-asteroid drawing flag for current pixel
//               ast_enabled    - per-asteroid enabled flag
//               bullet_drawing - bullet covers current pixel
//               ship_drawing   - ship covers current pixel
//               shot           - one-clk per-asteroid hit pulse
//               bullet_hit     - one-clk pulse, bullet consumed
//               game_over      - sticky ship-collision flag
//               score          - destroyed-asteroid count (saturating)
// Revision    : 1.0 - initial release
// ============================================================================
module asteroid_collide
  import asteroid_pkg::*;
#(
  parameter int ASTEROID_COUNT = DEFAULT_ASTEROID_COUNT,
  parameter int SCORE_W        = DEFAULT_SCORE_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame,
  input  logic [ASTEROID_COUNT-1:0] ast_drawing,
  input  logic [ASTEROID_COUNT-1:0] ast_enabled,
  input  logic                      bullet_drawing,
  input  logic                      ship_drawing,
  output logic [ASTEROID_COUNT-1:0] shot,
  output logic                      bullet_hit,
  output logic                      game_over,
  output logic [SCORE_W-1:0]        score
);

  localparam int CNT_W = $clog2(ASTEROID_COUNT + 1);
  // One spare bit above the wider operand so the add can never wrap.
  localparam int SUM_W = ((SCORE_W > CNT_W) ? SCORE_W : CNT_W) + 1;

  // Sample stage: all detection works on these registered copies.
  logic                      s_bullet;
  logic [ASTEROID_COUNT-1:0] s_draw;
  logic [ASTEROID_COUNT-1:0] s_en;

  logic [ASTEROID_COUNT-1:0] pending;
  logic [ASTEROID_COUNT-1:0] hit_vec;
  logic [ASTEROID_COUNT-1:0] commit_vec;
  logic [CNT_W-1:0]          commit_cnt;
  logic [SUM_W-1:0]          score_sum;
  logic [SCORE_W-1:0]        score_nxt;
  logic                      in_play;

  assign hit_vec    = {ASTEROID_COUNT{s_bullet}} & s_draw & s_en;
  // An asteroid disabled between the hit and the commit is not credited.
  assign commit_vec = pending & ast_enabled;

  popcount #(
    .WIDTH (ASTEROID_COUNT)
  ) u_popcount (
    .bits  (commit_vec),
    .count (commit_cnt)
  );

  assign score_sum = SUM_W'(score) + SUM_W'(commit_cnt);
  assign score_nxt = (score_sum > SUM_W'({SCORE_W{1'b1}})) ? {SCORE_W{1'b1}}
                                                           : score_sum[SCORE_W-1:0];

`ifdef SHIP_COLLIDE_EN
  game_state_e state;
  game_state_e state_nxt;
  logic        s_ship;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= PLAY;
      s_ship <= 1'b0;
    end else begin
      state  <= state_nxt;
      s_ship <= ship_drawing;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      PLAY:    if (s_ship && |(s_draw & s_en)) state_nxt = OVER;
      OVER:    state_nxt = OVER;
      default: state_nxt = PLAY;
    endcase
  end

  assign in_play   = (state == PLAY);
  assign game_over = (state == OVER);
`else
  logic unused_ship;
  assign unused_ship = ship_drawing;
  assign in_play     = 1'b1;
  assign game_over   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_bullet   <= 1'b0;
      s_draw     <= '0;
      s_en       <= '0;
      pending    <= '0;
      shot       <= '0;
      bullet_hit <= 1'b0;
      score      <= '0;
    end else begin
      s_bullet <= bullet_drawing;
      s_draw   <= ast_drawing;
      s_en     <= ast_enabled;
      if (frame) begin
        shot       <= in_play ? commit_vec : '0;
        bullet_hit <= in_play & (|commit_vec);
        if (in_play) score <= score_nxt;
        // Clear-then-set: a hit sampled now belongs to the new frame.
        pending    <= in_play ? hit_vec : '0;
      end else begin
        shot       <= '0;
        bullet_hit <= 1'b0;
        if (in_play) pending <= pending | hit_vec;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_asteroid_collide.sv
`default_nettype none
// ============================================================================
// Module      : tb_asteroid_collide
// Description : Directed self-checking bench for asteroid_collide. A second
//               instance with SCORE_W = 2 shares the stimulus to exercise
//               score saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_asteroid_collide;

  localparam int N = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         frame = 1'b0;
  logic [N-1:0] ast_drawing = '0;
  logic [N-1:0] ast_enabled = '1;
  logic         bullet_drawing = 1'b0;
  logic         ship_drawing = 1'b0;

  logic [N-1:0] shot, shot2;
  logic         bullet_hit, bullet_hit2;
  logic         game_over, game_over2;
  logic [15:0]  score;
  logic [1:0]   score2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  asteroid_collide #(.ASTEROID_COUNT(N), .SCORE_W(16)) dut (
    .clk(clk), .rst(rst), .frame(frame), .ast_drawing(ast_drawing),
    .ast_enabled(ast_enabled), .bullet_drawing(bullet_drawing),
    .ship_drawing(ship_drawing), .shot(shot), .bullet_hit(bullet_hit),
    .game_over(game_over), .score(score)
  );

  asteroid_collide #(.ASTEROID_COUNT(N), .SCORE_W(2)) dut_sat (
    .clk(clk), .rst(rst), .frame(frame), .ast_drawing(ast_drawing),
    .ast_enabled(ast_enabled), .bullet_drawing(bullet_drawing),
    .ship_drawing(ship_drawing), .shot(shot2), .bullet_hit(bullet_hit2),
    .game_over(game_over2), .score(score2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Bullet overlaps asteroids in mask for one pixel, then idle long enough
  // for the sampled hit to reach pending.
  task automatic overlap(input logic [N-1:0] mask, input logic [N-1:0] en);
    @(negedge clk);
    bullet_drawing = 1'b1;
    ast_drawing    = mask;
    ast_enabled    = en;
    @(negedge clk);
    bullet_drawing = 1'b0;
    ast_drawing    = '0;
    @(negedge clk);
  endtask

  // Frame pulse, then check the commit cycle and the cycle after it.
  task automatic do_frame(input string tag, input logic [N-1:0] exp_shot,
                          input logic [15:0] exp_score, input logic [1:0] exp_score2);
    @(negedge clk);
    frame = 1'b1;
    @(negedge clk);
    frame = 1'b0;
    chk({tag, "_shot"},   32'(shot),       32'(exp_shot));
    chk({tag, "_bhit"},   32'(bullet_hit), 32'(exp_shot != '0));
    chk({tag, "_score"},  32'(score),      32'(exp_score));
    chk({tag, "_score2"}, 32'(score2),     32'(exp_score2));
    @(negedge clk);
    chk({tag, "_shot_end"}, 32'(shot),       32'h0);
    chk({tag, "_bhit_end"}, 32'(bullet_hit), 32'h0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_shot",  32'(shot),       32'h0);
    chk("rst_bhit",  32'(bullet_hit), 32'h0);
    chk("rst_go",    32'(game_over),  32'h0);
    chk("rst_score", 32'(score),      32'h0);
    rst = 1'b0;

    // Frame with nothing pending: no pulses.
    do_frame("empty", 10'h000, 16'd0, 2'd0);

    overlap(10'h008, 10'h3FF);
    do_frame("single", 10'h008, 16'd1, 2'd1);

    overlap(10'h012, 10'h3FF);
    do_frame("multi", 10'h012, 16'd3, 2'd3);

    overlap(10'h004, 10'h3FB);
    ast_enabled = '1;
    do_frame("disabled", 10'h000, 16'd3, 2'd3);

    // Overlap sampled on the frame edge must land in the next frame.
    @(negedge clk);
    bullet_drawing = 1'b1;
    ast_drawing    = 10'h020;
    @(negedge clk);
    bullet_drawing = 1'b0;
    ast_drawing    = '0;
    frame          = 1'b1;
    @(negedge clk);
    frame = 1'b0;
    chk("coinc_now_shot", 32'(shot),       32'h0);
    chk("coinc_now_bhit", 32'(bullet_hit), 32'h0);
    do_frame("coinc_next", 10'h020, 16'd4, 2'd3);

    // Two more hits; the 2-bit score stays pinned at 3.
    overlap(10'h180, 10'h3FF);
    do_frame("sat", 10'h180, 16'd6, 2'd3);

    // Reset mid-frame discards pending hits and clears outputs at once.
    overlap(10'h040, 10'h3FF);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_score",  32'(score),      32'h0);
    chk("mid_rst_score2", 32'(score2),     32'h0);
    chk("mid_rst_shot",   32'(shot),       32'h0);
    chk("mid_rst_go",     32'(game_over),  32'h0);
    @(negedge clk);
    rst = 1'b0;
    do_frame("post_rst", 10'h000, 16'd0, 2'd0);
    overlap(10'h004, 10'h3FF);
    do_frame("post_rst_hit", 10'h004, 16'd1, 2'd1);

    // Ship overlapping an enabled asteroid.
    @(negedge clk);
    ship_drawing = 1'b1;
    ast_drawing  = 10'h001;
    @(negedge clk);
    ship_drawing = 1'b0;
    ast_drawing  = '0;
    @(negedge clk);
`ifdef SHIP_COLLIDE_EN
    chk("ship_go", 32'(game_over), 32'h1);
    overlap(10'h008, 10'h3FF);
    do_frame("over_frozen", 10'h000, 16'd1, 2'd1);
    chk("ship_go_sticky", 32'(game_over), 32'h1);
`else
    chk("ship_go_off", 32'(game_over), 32'h0);
    overlap(10'h008, 10'h3FF);
    do_frame("ship_off_hit", 10'h008, 16'd2, 2'd2);
    chk("ship_go_off2", 32'(game_over), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/asteroid_collide.md
ASTEROID_COLLIDE -- requirements
Module: asteroid_collide

Interface
REQ-001 SHALL have parameter ASTEROID_COUNT, default 10, number of asteroid instances checked.
REQ-002 SHALL have parameter SCORE_W, default 16, score counter width.
REQ-003 SHALL have port clk  input  1  pixel clock; the only clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port frame  input  1  one-clk pulse at start of vertical blank.
REQ-006 SHALL have port ast_drawing  input  ASTEROID_COUNT  per-asteroid drawing flag for the current pixel.
REQ-007 SHALL have port ast_enabled  input  ASTEROID_COUNT  per-asteroid enabled flag.
REQ-008 SHALL have port bullet_drawing  input  1  bullet sprite covers the current pixel.
REQ-009 SHALL have port ship_drawing  input  1  ship sprite covers the current pixel.
REQ-010 SHALL have port shot  output  ASTEROID_COUNT  one-clk hit pulse per asteroid, fed to that asteroid's shot input.
REQ-011 SHALL have port bullet_hit  output  1  one-clk pulse, bullet consumed.
REQ-012 SHALL have port game_over  output  1  sticky ship-collision flag.
REQ-013 SHALL have port score  output  SCORE_W  destroyed-asteroid count.

Function
REQ-014 SHALL register all drawing and enable inputs in one sample stage; detection uses only sampled values.
REQ-015 SHALL set pending[i] when the sampled bullet_drawing, ast_drawing[i] and ast_enabled[i] are all 1; pending[i] holds until commit.
REQ-016 SHALL commit on the cycle after frame: shot <= pending AND the current ast_enabled, pending <= 0, for exactly one clk.
REQ-017 SHALL pulse bullet_hit in the commit cycle iff any committed shot bit is 1.
REQ-018 SHALL add the popcount of the committed shot bits to score in the commit cycle, saturating at all-ones.
REQ-019 SHALL attribute a sampled hit that coincides with the commit cycle to the new frame; pending is set after clearing, not lost.
REQ-020 SHALL implement FSM states PLAY and OVER; PLAY->OVER when sampled ship_drawing and any sampled (ast_drawing AND ast_enabled) bit are 1; OVER exits only on reset.
REQ-021 SHALL keep game_over = 1 in OVER; in OVER it SHALL accumulate no pending bits, hold shot and bullet_hit at 0, and freeze score.
REQ-022 SHALL count several asteroids hit in one frame individually; bullet_hit still pulses once.
REQ-023 SHALL generate no output pulses for a frame pulse that occurs with pending all 0.

Reset
REQ-024 SHALL, on rst asserted, immediately clear shot, bullet_hit, game_over, score, pending and the sample stage, and force state PLAY.
REQ-025 SHALL discard pending hits when reset occurs mid-frame; the first commit after reset reflects only post-reset hits.

Configuration
REQ-026 SHALL, with SHIP_COLLIDE_EN defined, implement REQ-020 and REQ-021 as stated.
REQ-027 SHALL, without SHIP_COLLIDE_EN, remove the FSM, tie game_over to 0 and ignore ship_drawing.

Structure
REQ-028 SHALL take ASTEROID_COUNT default, SCORE_W default and the PLAY/OVER state enum from shared package asteroid_pkg.
REQ-029 SHALL instantiate one sub-module, popcount, parameterised by width, for REQ-018.

Verification
REQ-030 SHALL verify single hit: bullet and ast_drawing[3] with enabled, then frame -> shot = 0x008 for 1 clk, bullet_hit pulses, score 0->1.
REQ-031 SHALL verify multi-hit: asteroids 1 and 4 overlap the bullet in one frame -> shot = 0x012, score +2, a single bullet_hit pulse.
REQ-032 SHALL verify disabled asteroid: ast_enabled[2] = 0 during overlap -> no shot, score unchanged.
REQ-033 SHALL verify frame coincidence: overlap sampled in the commit cycle -> shot appears at the next frame commit, not the current one.
REQ-034 SHALL verify ship collision (SHIP_COLLIDE_EN): ship overlaps enabled asteroid -> game_over = 1 the next clk; later bullet hits give no shot and score is frozen.
REQ-035 SHALL verify saturation and reset: score preset near max by 3 hits with SCORE_W = 2 -> score holds at 3; assert rst mid-frame -> all outputs 0 immediately.
